// File: rtl/div_issue_stage.sv
// Operand FIFO and registered result stage around a combinational divider.
// Zero divisors never reach the divider; they are resolved locally.
module div_issue_stage #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_dividend,
  input  logic [WIDTH-1:0]         in_divisor,
  output logic [WIDTH-1:0]         div_dividend,
  output logic [WIDTH-1:0]         div_divisor,
  input  logic [WIDTH-1:0]         div_quotient,
  input  logic [WIDTH-1:0]         div_remainder,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_quotient,
  output logic [WIDTH-1:0]         out_remainder,
  output logic                     out_div_by_zero,
  output logic [$clog2(DEPTH):0]   fifo_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] dvd_q [DEPTH];
  logic [WIDTH-1:0] dvd_d [DEPTH];
  logic [WIDTH-1:0] dvs_q [DEPTH];
  logic [WIDTH-1:0] dvs_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_quotient_q, out_quotient_d;
  logic [WIDTH-1:0] out_remainder_q, out_remainder_d;
  logic             out_dbz_q, out_dbz_d;

  logic             push;
  logic             load;
  logic             not_empty;
  logic             head_zero;
  logic [WIDTH-1:0] head_dvd;
  logic [WIDTH-1:0] head_dvs;

  // in_ready looks only at the registered count, so a full FIFO stays closed
  // even in a cycle that pops.
  assign in_ready  = reset && (count_q < CW'(DEPTH));
  assign not_empty = (count_q != '0);
  assign head_dvd  = dvd_q[rd_ptr_q];
  assign head_dvs  = dvs_q[rd_ptr_q];
  assign head_zero = (head_dvs == '0);
  assign push      = in_valid && in_ready;
  assign load      = not_empty && (!out_valid_q || out_ready);

  assign div_dividend = not_empty ? head_dvd : '0;
  assign div_divisor  = (not_empty && !head_zero) ? head_dvs : WIDTH'(1);

  assign out_valid       = out_valid_q;
  assign out_quotient    = out_quotient_q;
  assign out_remainder   = out_remainder_q;
  assign out_div_by_zero = out_dbz_q;
  assign fifo_count      = count_q;

  always_comb begin
    dvd_d           = dvd_q;
    dvs_d           = dvs_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    count_d         = count_q + CW'(push) - CW'(load);
    out_valid_d     = out_valid_q;
    out_quotient_d  = out_quotient_q;
    out_remainder_d = out_remainder_q;
    out_dbz_d       = out_dbz_q;

    if (push) begin
      dvd_d[wr_ptr_q] = in_dividend;
      dvs_d[wr_ptr_q] = in_divisor;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end

    if (load) begin
      rd_ptr_d    = rd_ptr_q + PW'(1);
      out_valid_d = 1'b1;
      if (head_zero) begin
        out_quotient_d  = '1;
        out_remainder_d = head_dvd;
        out_dbz_d       = 1'b1;
      end else begin
        out_quotient_d  = div_quotient;
        out_remainder_d = div_remainder;
        out_dbz_d       = 1'b0;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        dvd_q[i] <= '0;
        dvs_q[i] <= '0;
      end
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      out_valid_q     <= 1'b0;
      out_quotient_q  <= '0;
      out_remainder_q <= '0;
      out_dbz_q       <= 1'b0;
    end else begin
      dvd_q           <= dvd_d;
      dvs_q           <= dvs_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      out_valid_q     <= out_valid_d;
      out_quotient_q  <= out_quotient_d;
      out_remainder_q <= out_remainder_d;
      out_dbz_q       <= out_dbz_d;
    end
  end
endmodule

// File: tb/tb_div_issue_stage.sv
// Directed bench for div_issue_stage with a scoreboard of expected results.
module tb_div_issue_stage;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_dividend = '0;
  logic [WIDTH-1:0] in_divisor = '0;
  logic [WIDTH-1:0] div_dividend, div_divisor, div_quotient, div_remainder;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_quotient, out_remainder;
  logic             out_div_by_zero;
  logic [$clog2(DEPTH):0] fifo_count;

  typedef struct packed {
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             dbz;
  } res_t;

  res_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // Behavioural stand-in for the combinational divider.
  assign div_quotient  = div_dividend / div_divisor;
  assign div_remainder = div_dividend % div_divisor;

  div_issue_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_dividend(in_dividend), .in_divisor(in_divisor),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .div_remainder(div_remainder),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_quotient(out_quotient), .out_remainder(out_remainder),
    .out_div_by_zero(out_div_by_zero), .fifo_count(fifo_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_pair(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    res_t e;
    if (b == 0) begin
      e.q = '1; e.r = a; e.dbz = 1'b1;
    end else begin
      e.q = a / b; e.r = a % b; e.dbz = 1'b0;
    end
    sb.push_back(e);
    $display("push dividend=%0d divisor=%0d exp_q=%0h exp_r=%0h exp_dbz=%0b", a, b, e.q, e.r, e.dbz);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard side: a result transfers at the edge following this sample.
  always @(negedge clk) begin
    if (reset) begin
      check("div_divisor_nonzero", 32'(div_divisor != 0), 32'd1);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_result", 32'd1, 32'd0);
        end else begin
          res_t e;
          e = sb.pop_front();
          check("result_q", 32'(out_quotient), 32'(e.q));
          check("result_r", 32'(out_remainder), 32'(e.r));
          check("result_dbz", 32'(out_div_by_zero), 32'(e.dbz));
          $display("pop q=%0h r=%0h dbz=%0b", out_quotient, out_remainder, out_div_by_zero);
        end
      end
    end
  end

  initial begin
    logic [WIDTH-1:0] dv [5];
    logic [WIDTH-1:0] ds [5];
    logic [WIDTH-1:0] hq, hr;
    int idx;
    bit acc;
    dv = '{8'd50, 8'd77, 8'd9, 8'd255, 8'd1};
    ds = '{8'd3, 8'd0, 8'd4, 8'd16, 8'd1};

    // Reset state
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    check("rst_out_q", 32'(out_quotient), 32'd0);
    check("rst_div_divisor", 32'(div_divisor), 32'd1);
    step();
    reset = 1'b1;
    step();
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // 100/7 latency
    out_ready = 1'b1;
    in_valid = 1'b1; in_dividend = 8'd100; in_divisor = 8'd7;
    expect_pair(8'd100, 8'd7);
    step();
    in_valid = 1'b0;
    check("t1_valid_e0", 32'(out_valid), 32'd0);
    check("t1_count_e0", 32'(fifo_count), 32'd1);
    check("t1_div_dividend", 32'(div_dividend), 32'd100);
    check("t1_div_divisor", 32'(div_divisor), 32'd7);
    step();
    check("t1_valid_e1", 32'(out_valid), 32'd1);
    check("t1_q", 32'(out_quotient), 32'd14);
    check("t1_r", 32'(out_remainder), 32'd2);
    check("t1_dbz", 32'(out_div_by_zero), 32'd0);
    step();
    check("t1_drained", 32'(out_valid), 32'd0);

    // 200/0
    in_valid = 1'b1; in_dividend = 8'd200; in_divisor = 8'd0;
    expect_pair(8'd200, 8'd0);
    step();
    in_valid = 1'b0;
    check("t2_div_divisor", 32'(div_divisor), 32'd1);
    check("t2_div_dividend", 32'(div_dividend), 32'd200);
    step();
    check("t2_q", 32'(out_quotient), 32'hFF);
    check("t2_r", 32'(out_remainder), 32'hC8);
    check("t2_dbz", 32'(out_div_by_zero), 32'd1);
    step();

    // Back-to-back 5/9 then FF/1
    in_valid = 1'b1; in_dividend = 8'd5; in_divisor = 8'd9;
    expect_pair(8'd5, 8'd9);
    step();
    in_dividend = 8'hFF; in_divisor = 8'd1;
    expect_pair(8'hFF, 8'd1);
    step();
    in_valid = 1'b0;
    check("t3_first_valid", 32'(out_valid), 32'd1);
    check("t3_first_q", 32'(out_quotient), 32'd0);
    check("t3_first_r", 32'(out_remainder), 32'd5);
    step();
    check("t3_second_valid", 32'(out_valid), 32'd1);
    check("t3_second_q", 32'(out_quotient), 32'hFF);
    check("t3_second_r", 32'(out_remainder), 32'd0);
    step();
    check("t3_drained", 32'(out_valid), 32'd0);

    // Backpressure: fill FIFO and output stage
    out_ready = 1'b0;
    idx = 0;
    in_valid = 1'b1;
    for (int c = 0; c < 12 && idx < 5; c++) begin
      in_dividend = dv[idx]; in_divisor = ds[idx];
      acc = in_ready;
      step();
      if (acc) begin
        expect_pair(dv[idx], ds[idx]);
        idx++;
        if (idx == 4) check("t4_count_after_4", 32'(fifo_count), 32'd3);
      end
    end
    in_valid = 1'b0;
    check("t4_accepted", 32'(idx), 32'd5);
    check("t4_count_full", 32'(fifo_count), 32'd4);
    check("t4_in_ready_full", 32'(in_ready), 32'd0);
    hq = 8'd16; hr = 8'd2;
    for (int c = 0; c < 10; c++) begin
      step();
      check("t4_hold_valid", 32'(out_valid), 32'd1);
      check("t4_hold_q", 32'(out_quotient), 32'(hq));
      check("t4_hold_r", 32'(out_remainder), 32'(hr));
      check("t4_hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check("t4_drain_valid", 32'(out_valid), 32'd1);
      step();
    end
    check("t4_drain_done", 32'(out_valid), 32'd0);
    check("t4_sb_empty", 32'(sb.size()), 32'd0);

    // Async reset mid-stream
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      in_dividend = 8'(10 + c); in_divisor = 8'd3;
      step();
    end
    in_valid = 1'b0;
    check("t5_pre_count", 32'(fifo_count), 32'd3);
    check("t5_pre_valid", 32'(out_valid), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("t5_rst_valid", 32'(out_valid), 32'd0);
    check("t5_rst_count", 32'(fifo_count), 32'd0);
    check("t5_rst_in_ready", 32'(in_ready), 32'd0);
    sb.delete();
    step();
    step();
    reset = 1'b1;
    #1;
    check("t5_rel_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      check("t5_no_stale", 32'(out_valid), 32'd0);
      check("t5_count_zero", 32'(fifo_count), 32'd0);
    end
    check("t5_sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
